// File: rtl/mem_accum_pkg.sv
// Shared constants for the memory accumulation engine: FSM encoding and add/sub mode values.
package mem_accum_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/mem_accum_unit_shift_reg_n.sv
// Operand register: parallel load takes priority over a right shift with serial MSB input.
module shift_reg_n #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_data_i;
    end else if (shift_i) begin
      q_q <= {shift_in_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_accum_unit.sv
// Multi-cycle engine that streams consecutive memory words through an add/sub unit onto a
// captured operand, reporting the sum with sticky carry/borrow and signed-overflow flags.
module mem_accum_unit
  import mem_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             sh_load,
  input  logic [WIDTH-1:0] sh_data,
  input  logic             sh_en,
  input  logic             sh_in,
  output logic [WIDTH-1:0] operand,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam logic [AW:0]   RemOne  = (AW+1)'(1);
  localparam logic [AW:0]   RemZero = '0;
  localparam logic [AW-1:0] AddrOne = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             c_acc_q, c_acc_d;
  logic             v_acc_q, v_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             step_c, step_v;
  logic             a_msb, d_msb, s_msb;

  shift_reg_n #(
    .WIDTH (WIDTH)
  ) u_operand (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (sh_load),
    .load_data_i (sh_data),
    .shift_i     (sh_en),
    .shift_in_i  (sh_in),
    .q_o         (operand)
  );

  // Memory is deliberately left out of reset; a same-address read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (state_q == StRun) begin
      rdata_q <= mem[rd_addr_q];
    end
  end

  // Subtract is acc + ~d + 1, so the borrow is the inverted carry out.
  assign addend = (mode_q == MODE_SUB) ? ~rdata_q : rdata_q;
  assign sum    = {1'b0, acc_q} + {1'b0, addend} + {{WIDTH{1'b0}}, mode_q};
  assign a_msb  = acc_q[WIDTH-1];
  assign d_msb  = rdata_q[WIDTH-1];
  assign s_msb  = sum[WIDTH-1];
  assign step_c = (mode_q == MODE_SUB) ? ~sum[WIDTH] : sum[WIDTH];
  assign step_v = (mode_q == MODE_SUB) ? ((a_msb != d_msb) && (s_msb != a_msb))
                                       : ((a_msb == d_msb) && (s_msb != a_msb));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    c_acc_d   = c_acc_q;
    v_acc_d   = v_acc_q;
    busy_d    = busy_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    done_d    = (state_q == StFin);

    case (state_q)
      StIdle: begin
        if (start) begin
          if (count != RemZero) begin
            acc_d     = operand;
            c_acc_d   = 1'b0;
            v_acc_d   = 1'b0;
            rd_addr_d = base_addr;
            rem_d     = count;
            mode_d    = mode;
            busy_d    = 1'b1;
            state_d   = StRun;
          end else begin
            result_d = operand;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            state_d  = StFin;
          end
        end
      end
      StRun: begin
        rd_addr_d = rd_addr_q + AddrOne;
        rem_d     = rem_q - RemOne;
        // The first RUN cycle has no read data returning yet.
        if (rvalid_q) begin
          acc_d   = sum[WIDTH-1:0];
          c_acc_d = c_acc_q | step_c;
          v_acc_d = v_acc_q | step_v;
        end
        if (rem_q == RemOne) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d    = sum[WIDTH-1:0];
        result_d = sum[WIDTH-1:0];
        carry_d  = c_acc_q | step_c;
        ovf_d    = v_acc_q | step_v;
        state_d  = StFin;
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      rd_addr_q <= '0;
      rem_q     <= '0;
      mode_q    <= MODE_ADD;
      c_acc_q   <= 1'b0;
      v_acc_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      c_acc_q   <= c_acc_d;
      v_acc_q   <= v_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      rvalid_q  <= (state_q == StRun);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mem_accum_unit.sv
// Directed plus randomized bench for mem_accum_unit against a plain-arithmetic job model.
module tb_mem_accum_unit;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          sh_load;
  logic [W-1:0]  sh_data;
  logic          sh_en;
  logic          sh_in;
  logic [W-1:0]  operand;
  logic          start;
  logic          mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] mem_m [D];
  logic [W-1:0] op_m;

  mem_accum_unit #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sh_load   (sh_load),
    .sh_data   (sh_data),
    .sh_en     (sh_en),
    .sh_in     (sh_in),
    .operand   (operand),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en    = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic load_op(input logic [W-1:0] v);
    sh_load = 1'b1;
    sh_data = v;
    step();
    sh_load = 1'b0;
    op_m    = v;
  endtask

  task automatic shift_op(input logic b);
    sh_en = 1'b1;
    sh_in = b;
    step();
    sh_en = 1'b0;
    op_m  = (op_m >> 1) | ({31'd0, b} << 31);
  endtask

  // Job semantics: unsigned carry/borrow and signed overflow judged on wide integers.
  function automatic void model(input int base, input int cnt, input logic md,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic [W-1:0] d;
    longint ua, ud, sa, sd, sr;
    r = op_m;
    c = 1'b0;
    v = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      d  = mem_m[(base + i) % D];
      ua = longint'(r);
      ud = longint'(d);
      sa = longint'($signed(r));
      sd = longint'($signed(d));
      if (md == 1'b0) begin
        c  = c | ((ua + ud) > 64'sh0FFFFFFFF);
        sr = sa + sd;
        r  = r + d;
      end else begin
        c  = c | (ua < ud);
        sr = sa - sd;
        r  = r - d;
      end
      v = v | (sr > SMAX) | (sr < SMIN);
    end
  endfunction

  task automatic run_job(input string tag, input int base, input int cnt, input logic md,
                         input bit glitch, input bit perturb);
    logic [W-1:0] er;
    logic         ec, ev;
    logic [W-1:0] pval;
    int           n;
    int           lat;
    bit           got;
    model(base, cnt, md, er, ec, ev);
    lat       = (cnt == 0) ? 1 : cnt + 2;
    pval      = $urandom;
    start     = 1'b1;
    mode      = md;
    base_addr = AW'(base);
    count     = (AW+1)'(cnt);
    step();
    start = 1'b0;
    n     = 0;
    got   = 0;
    while (!got && n < 60) begin
      sh_load = perturb && (n == 0);
      sh_data = pval;
      if (glitch && n == 2) begin
        start     = 1'b1;
        mode      = ~md;
        base_addr = AW'(base + 3);
        count     = (AW+1)'(1);
      end else begin
        start = 1'b0;
      end
      step();
      n++;
      if (n == 1) check({tag, " busy"}, {63'd0, busy}, {63'd0, (cnt > 0)});
      if (done) got = 1;
    end
    start   = 1'b0;
    sh_load = 1'b0;
    if (perturb) op_m = pval;
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, {32'd0, result}, {32'd0, er});
    check({tag, " carry"}, {63'd0, carry_out}, {63'd0, ec});
    check({tag, " ovf"}, {63'd0, overflow}, {63'd0, ev});
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    step();
    check({tag, " done_once"}, {63'd0, done}, 64'd0);
    if (glitch) begin
      got = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (done) got = 1;
      end
      check({tag, " no_extra_done"}, {63'd0, got}, 64'd0);
    end
  endtask

  initial begin
    int   pulses;
    logic b;
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; sh_load = 0; sh_data = 0;
    sh_en = 0; sh_in = 0; start = 0; mode = 0; base_addr = 0; count = 0;
    op_m = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", {32'd0, result}, 64'd0);
    check("reset flags", {62'd0, carry_out, overflow}, 64'd0);
    check("reset operand", {32'd0, operand}, 64'd0);

    for (int i = 0; i < D; i++) mem_write(i, $urandom);

    for (int i = 0; i < 4; i++) mem_write(i, 32'(i + 1));
    load_op(32'd10);
    run_job("sum4", 0, 4, 1'b0, 0, 0);
    check("sum4 literal", {32'd0, result}, 64'd20);

    load_op(32'd5);
    mem_write(2, 32'd7);
    run_job("sub1", 2, 1, 1'b1, 0, 0);
    check("sub1 literal", {32'd0, result}, 64'h0FFFFFFFE);

    load_op(32'h7FFFFFFF);
    mem_write(5, 32'd1);
    run_job("ovf", 5, 1, 1'b0, 0, 0);
    check("ovf literal", {32'd0, result}, 64'h080000000);

    load_op(32'd1);
    mem_write(6, 32'hFFFFFFFF);
    run_job("carry", 6, 1, 1'b0, 0, 0);

    mem_write(14, 32'd1);
    mem_write(15, 32'd2);
    mem_write(0, 32'd4);
    mem_write(1, 32'd8);
    load_op(32'd0);
    run_job("wrap", 14, 4, 1'b0, 1, 0);
    check("wrap literal", {32'd0, result}, 64'd15);

    load_op(32'd0);
    for (int i = 0; i < W; i++) shift_op(1'b1);
    check("shift ones", {32'd0, operand}, 64'h0FFFFFFFF);
    run_job("cnt0", 0, 0, 1'b0, 0, 0);

    for (int i = 0; i < 8; i++) mem_write(i, $urandom);
    load_op($urandom);
    start     = 1'b1;
    mode      = 1'b0;
    base_addr = '0;
    count     = (AW+1)'(8);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    op_m = '0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort result", {32'd0, result}, 64'd0);
    check("abort flags", {62'd0, carry_out, overflow}, 64'd0);
    check("abort operand", {32'd0, operand}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) pulses++;
    end
    check("abort no_done", 64'(pulses), 64'd0);
    run_job("post_abort", 0, 8, 1'b0, 0, 0);

    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < 3; k++) mem_write($urandom_range(0, D - 1), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        load_op($urandom);
      end else begin
        for (int k = 0; k < 5; k++) begin
          b = 1'($urandom_range(0, 1));
          shift_op(b);
        end
        check("rand shift", {32'd0, operand}, {32'd0, op_m});
      end
      run_job("rand", $urandom_range(0, D - 1), $urandom_range(0, 20),
              1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_accum_unit.md
Name: mem_accum_unit

Overview:
- Parametrised successor to the fetch-register-adder datapath.
- Holds a writable word memory and a loadable/serial-shift operand register.
- On a start command, an FSM streams a block of consecutive memory words through an add/subtract unit, accumulating onto the operand.
- Reports the result with sticky carry/borrow and correct signed-overflow flags; sits beside the instruction/data path as a multi-cycle arithmetic engine.

Parameters:
- WIDTH, 32, data word width in bits (>=2).
- DEPTH, 16, memory words (power of two, >=2); AW = $clog2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  memory write strobe.
- wr_addr  input  AW  memory write address.
- wr_data  input  WIDTH  memory write data.
- sh_load  input  1  parallel-load operand register from sh_data.
- sh_data  input  WIDTH  parallel load value.
- sh_en  input  1  shift operand register right one bit.
- sh_in  input  1  serial bit entering at MSB.
- operand  output  WIDTH  current operand register contents.
- start  input  1  begin accumulation (sampled in IDLE only).
- mode  input  1  0 = add, 1 = subtract; sampled with start.
- base_addr  input  AW  first word address; sampled with start.
- count  input  AW+1  number of words to accumulate; sampled with start.
- busy  output  1  high while a job is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  accumulated value, held until next start.
- carry_out  output  1  sticky unsigned carry (add) / borrow (sub).
- overflow  output  1  sticky signed overflow.

Behaviour:
- Reset: busy, done, result, carry_out and overflow = 0; operand register = 0; FSM -> IDLE. Memory contents are not reset.
- Reset mid-job aborts the job: no done pulse; memory is retained.
- Operand register: sh_load has priority over sh_en. Shift is right: q[WIDTH-1] <= sh_in, q[k] <= q[k+1]. It remains writable while busy; the value is captured at start, so later changes do not affect the running job.
- Memory: synchronous write, synchronous read with 1-cycle latency. Writes are allowed while busy. Read and write to the same address in the same cycle returns the old data.
- FSM states are IDLE, RUN, DRAIN, FIN.
- IDLE, start=1, count>0:
  - acc <= operand; flags cleared; rd_addr <= base_addr; remaining <= count; busy <= 1; -> RUN.
- IDLE, start=1, count=0:
  - result <= operand; flags <= 0; -> FIN.
- RUN: each cycle issues a read at rd_addr, increments rd_addr modulo DEPTH (wraps), and decrements remaining.
  - Read data returning from the previous cycle's read is accumulated.
  - When remaining reaches 1, -> DRAIN.
- DRAIN: accumulate the last word; result <= final sum; flags <= final sticky values; -> FIN.
- FIN: done = 1 for exactly one cycle; busy <= 0; -> IDLE.
- Latency: done is high in the cycle count+2 edges after the start edge (count>0), or 1 edge after it (count=0).
- Start while busy is ignored.
- count > DEPTH is legal; addresses wrap and words are re-read.
- Arithmetic: add computes acc + d; subtract computes acc + ~d + 1. Results are truncated to WIDTH.
- Per-step flags:
  - Add carry = bit WIDTH of the sum.
  - Subtract borrow = NOT bit WIDTH.
  - Add overflow = (a_msb == d_msb) && (s_msb != a_msb).
  - Subtract overflow = (a_msb != d_msb) && (s_msb != a_msb).
- Flags are ORed across all steps (sticky within a job).
- result, carry_out and overflow update only at DRAIN/FIN and are otherwise stable.

Decomposition:
- Package mem_accum_pkg: FSM state enum (IDLE, RUN, DRAIN, FIN); mode constants MODE_ADD = 1'b0, MODE_SUB = 1'b1.
- Sub-module shift_reg_n (WIDTH parameter): load/shift operand register.
- Adder/flag logic and memory stay inline.

Test Plan:
- mem[0..3] = 1, 2, 3, 4; sh_load 10; start base 0, count 4, add -> done 6 cycles after the start edge; result 20; carry_out 0; overflow 0; busy high for cycles 1–5.
- sh_load 5; mem[2] = 7; start base 2, count 1, sub -> result 0xFFFFFFFE; carry_out 1 (borrow); overflow 0.
- Overflow cases:
  - Operand 0x7FFFFFFF, mem[5] = 1, add -> result 0x80000000; overflow 1; carry_out 0.
  - Operand 1, mem[6] = 0xFFFFFFFF, add -> result 0; carry_out 1; overflow 0.
- Wrap: mem[14], mem[15], mem[0], mem[1] = 1, 2, 4, 8; operand 0; base 14, count 4 -> result 15. A second start asserted during the job is ignored (exactly one done pulse).
- Count 0 and shifting:
  - sh_load 0, then 32 cycles of sh_en with sh_in = 1 -> operand 0xFFFFFFFF.
  - Start with count 0 -> done the next cycle; result 0xFFFFFFFF; flags 0.
- Reset mid-job: rst asserted in the 2nd RUN cycle of a count 8 job -> next cycle busy, done, result and flags are 0; no done pulse follows. A new job afterwards returns correct sums from the unchanged memory.
